// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed RAM behind a req/gnt/rvalid bus, loaded via a side write port.
// Latency: a grant in cycle N produces rvalid in cycle N+LATENCY, fully pipelined and in order.
// Backpressure: gnt drops under throttle, a load write, or when MAX_OUTSTANDING responses are in flight.
module instr_mem_responder #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        gnt_throttle_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // Instruction storage; deliberately not reset so a loaded program survives a core reset.
    logic [31:0] mem [MEM_WORDS];

    // Response pipeline: stage 0 is written on the grant edge, the last stage drives the bus.
    logic [LATENCY-1:0] stage_vld;
    logic [LATENCY-1:0] stage_err;
    logic [31:0]        stage_dat [LATENCY];

    // Granted-but-unanswered request count.
    logic [CW-1:0] outstanding;

    logic [31:0]   rd_off;
    logic          rd_in_range;
    logic          rd_bad;
    logic [AW-1:0] rd_idx;

    logic [31:0]   ld_off;
    logic          ld_in_range;
    logic          ld_ok;
    logic [AW-1:0] ld_idx;

    logic slot_free;
    logic gnt;

    // Fetch address decode: an offset past the array or a non-word address turns into an error response.
    always_comb begin
        rd_off      = instr_addr_i - BASE_ADDR;
        rd_in_range = (instr_addr_i >= BASE_ADDR) && ({2'b00, rd_off[31:2]} < 32'(MEM_WORDS));
        rd_bad      = !rd_in_range || (rd_off[1:0] != 2'b00);
        rd_idx      = rd_off[AW+1:2];
    end

    // Load address decode: bad load addresses are dropped rather than aliased onto a valid word.
    always_comb begin
        ld_off      = load_addr_i - BASE_ADDR;
        ld_in_range = (load_addr_i >= BASE_ADDR) && ({2'b00, ld_off[31:2]} < 32'(MEM_WORDS));
        ld_ok       = ld_in_range && (ld_off[1:0] == 2'b00);
        ld_idx      = ld_off[AW+1:2];
    end

    // Grant: a response leaving this cycle frees its slot, so a full pipe can still grant back-to-back.
    always_comb begin
        slot_free = (outstanding < CW'(MAX_OUTSTANDING)) || instr_rvalid_o;
        gnt       = instr_req_i && !gnt_throttle_i && !load_we_i && slot_free;
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = stage_vld[LATENCY-1];
    assign instr_err_o    = stage_err[LATENCY-1];
    assign instr_rdata_o  = stage_dat[LATENCY-1];

    // Program load; gnt is forced low during a write so no read ever races the same edge.
    always_ff @(posedge clk) begin
        if (load_we_i && ld_ok) begin
            mem[ld_idx] <= load_wdata_i;
        end
    end

    // Response pipeline and outstanding counter; reset drops anything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_vld   <= '0;
            stage_err   <= '0;
            outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_dat[i] <= '0;
            end
        end else begin
            stage_vld[0] <= gnt;
            stage_err[0] <= gnt && rd_bad;
            // Data only moves with a valid response, so the bus holds its last rdata when idle.
            if (gnt) begin
                if (rd_bad) begin
                    stage_dat[0] <= '0;
                end else begin
                    stage_dat[0] <= mem[rd_idx];
                end
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_vld[i] <= stage_vld[i-1];
                stage_err[i] <= stage_vld[i-1] && stage_err[i-1];
                if (stage_vld[i-1]) begin
                    stage_dat[i] <= stage_dat[i-1];
                end
            end
            case ({gnt, instr_rvalid_o})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
